// File: rtl/bt_cmd_pkg.sv
// Shared types, command tables and helpers for the BT command scheduler.
package bt_cmd_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    BOOT  = 3'd1,
    ISEND = 3'd2,
    IWAIT = 3'd3,
    IDLE  = 3'd4,
    BSEND = 3'd5,
    BWAIT = 3'd6,
    RERST = 3'd7
  } state_t;

  typedef struct packed {
    logic [4:0] start;
    logic [3:0] len;
  } cmd_entry_t;

  // Init command list issued after the module's boot message.
  localparam cmd_entry_t INIT_TBL [4] = '{
    '{start: 5'd0,  len: 4'd6},
    '{start: 5'd6,  len: 4'd10},
    '{start: 5'd16, len: 4'd0},
    '{start: 5'd16, len: 4'd0}
  };

  // One command per button channel.
  localparam cmd_entry_t BTN_TBL [4] = '{
    '{start: 5'd16, len: 4'd4},
    '{start: 5'd20, len: 4'd4},
    '{start: 5'd24, len: 4'd4},
    '{start: 5'd28, len: 4'd4}
  };

  // Index of the lowest set bit; channel 0 has the highest priority.
  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    if (v[0]) begin
      r = 2'd0;
    end else if (v[1]) begin
      r = 2'd1;
    end else if (v[2]) begin
      r = 2'd2;
    end else if (v[3]) begin
      r = 2'd3;
    end else begin
      r = 2'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/bt_timer.sv
// Up-counter with synchronous clear and enable. tc is high during the
// (2^WIDTH-1)-th enabled cycle after a clear, so a state that holds en
// lasts exactly 2^WIDTH-1 cycles when it leaves on tc.
module bt_timer #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [WIDTH-1:0] TC_VAL = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0] cnt_r;

  // Count enabled cycles; clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = en && (cnt_r == TC_VAL);

endmodule

// File: rtl/bt_cmd_sched.sv
// BT module command scheduler: power-up hold, boot wait, init sequence,
// then queued button-command service with timeout, retry and re-reset.
module bt_cmd_sched
  import bt_cmd_pkg::*;
#(
  parameter int NUM_BTN       = 4,
  parameter int NUM_INIT      = 2,
  parameter int RST_WAIT_BITS = 17,
  parameter int TIMEOUT_BITS  = 20,
  parameter int MAX_RETRY     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_rel,
  input  logic               resp_rcvd,
  output logic               send,
  output logic [4:0]         cmd_start,
  output logic [3:0]         cmd_len,
  output logic               cmd_n,
  output logic               busy,
  output logic               init_done,
  output logic               err
);

  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [1:0]    LAST_IDX  = 2'(NUM_INIT - 1);

  state_t             state_r;
  logic [NUM_BTN-1:0] pending_r;
  logic [1:0]         idx_r;
  logic [RW-1:0]      retry_r;

  logic       hold_tc_s;
  logic       to_tc_s;
  logic       hold_en_s;
  logic       wait_en_s;
  logic       accept_s;
  logic [3:0] pend_ext_s;
  logic [1:0] sel_s;
  logic [3:0] pend_clr_s;
  logic [1:0] idx_inc_s;

  // Timer controls, button acceptance and next-to-serve selection.
  always_comb begin
    hold_en_s  = (state_r == HOLD);
    wait_en_s  = (state_r == BOOT) || (state_r == IWAIT) || (state_r == BWAIT);
    accept_s   = (state_r != HOLD) && (state_r != BOOT) && (state_r != RERST);
    pend_ext_s = 4'b0000;
    pend_ext_s[NUM_BTN-1:0] = pending_r;
    sel_s      = lowest_idx(pend_ext_s);
    pend_clr_s = pend_ext_s & ~(4'b0001 << sel_s);
    idx_inc_s  = idx_r + 2'd1;
  end

  // Timers are cleared whenever their state is not active, so every
  // entry into HOLD or a wait state starts from zero.
  bt_timer #(.WIDTH(RST_WAIT_BITS)) u_hold_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!hold_en_s),
    .en    (hold_en_s),
    .tc    (hold_tc_s)
  );

  bt_timer #(.WIDTH(TIMEOUT_BITS)) u_to_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!wait_en_s),
    .en    (wait_en_s),
    .tc    (to_tc_s)
  );

  // Main sequencer; outputs are set on entry to the state they belong to,
  // so send is high exactly during ISEND/BSEND. A resend reuses the held
  // cmd_start/cmd_len, which still describe the command being retried.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= HOLD;
      pending_r <= '0;
      idx_r     <= 2'd0;
      retry_r   <= '0;
      send      <= 1'b0;
      cmd_start <= 5'd0;
      cmd_len   <= 4'd0;
      cmd_n     <= 1'b1;
      busy      <= 1'b1;
      init_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      send <= 1'b0;
      if (accept_s) begin
        pending_r <= pending_r | btn_rel;
      end else begin
        pending_r <= pending_r;
      end
      case (state_r)
        HOLD: begin
          if (hold_tc_s) begin
            state_r <= BOOT;
            cmd_n   <= 1'b0;
          end
        end
        BOOT: begin
          if (resp_rcvd) begin
            idx_r     <= 2'd0;
            state_r   <= ISEND;
            send      <= 1'b1;
            cmd_start <= INIT_TBL[0].start;
            cmd_len   <= INIT_TBL[0].len;
          end else if (to_tc_s) begin
            state_r <= RERST;
          end
        end
        ISEND: begin
          state_r <= IWAIT;
        end
        IWAIT: begin
          if (resp_rcvd) begin
            retry_r <= '0;
            idx_r   <= idx_inc_s;
            if (idx_r == LAST_IDX) begin
              init_done <= 1'b1;
              busy      <= 1'b0;
              state_r   <= IDLE;
            end else begin
              state_r   <= ISEND;
              send      <= 1'b1;
              cmd_start <= INIT_TBL[idx_inc_s].start;
              cmd_len   <= INIT_TBL[idx_inc_s].len;
            end
          end else if (to_tc_s) begin
            if (retry_r < RETRY_MAX) begin
              retry_r <= retry_r + 1'b1;
              state_r <= ISEND;
              send    <= 1'b1;
            end else begin
              state_r <= RERST;
            end
          end
        end
        IDLE: begin
          if (|pending_r) begin
            // A pulse arriving on the channel being cleared is kept.
            pending_r <= pend_clr_s[NUM_BTN-1:0] | btn_rel;
            state_r   <= BSEND;
            busy      <= 1'b1;
            send      <= 1'b1;
            cmd_start <= BTN_TBL[sel_s].start;
            cmd_len   <= BTN_TBL[sel_s].len;
          end
        end
        BSEND: begin
          state_r <= BWAIT;
        end
        BWAIT: begin
          if (resp_rcvd) begin
            retry_r <= '0;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (to_tc_s) begin
            if (retry_r < RETRY_MAX) begin
              retry_r <= retry_r + 1'b1;
              state_r <= BSEND;
              send    <= 1'b1;
            end else begin
              state_r <= RERST;
            end
          end
        end
        RERST: begin
          err       <= 1'b1;
          init_done <= 1'b0;
          pending_r <= '0;
          retry_r   <= '0;
          cmd_n     <= 1'b1;
          state_r   <= HOLD;
        end
        default: begin
          state_r <= RERST;
        end
      endcase
    end
  end

endmodule
